// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads, buffers fetched
// words in a small FIFO and presents {instruction, PC+4, valid} to decode.
// Stops fetching after a HALT word; redirects flush the buffer and refetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic        halted
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr_mem [BUF_DEPTH];
  logic [31:0]        r_npc_mem   [BUF_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_is_halt;
  logic [31:0]        w_pc_plus4;

  // Request/handshake qualifiers and combinational head-of-FIFO outputs
  always_comb begin
    iREN       = (r_state == ST_FETCH) && (r_count < DEPTH_C) && !RST && !redirect;
    iaddr      = r_pc;
    w_pc_plus4 = r_pc + 32'd4;
    w_push     = iREN && ihit;
    w_is_halt  = (iload[31:26] == 6'b111111);
    valid_out  = (r_count != '0);
    // A redirect flushes the buffer, so no pop is credited that cycle
    w_pop      = valid_out && !stall && !redirect;
    halted     = (r_state == ST_HALTED);
    instr_out  = valid_out ? r_instr_mem[r_head] : '0;
    npc_out    = valid_out ? r_npc_mem[r_head]   : '0;
  end

  // FSM next-state: redirect always resumes fetching, an accepted HALT stops it
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = ST_FETCH;
    end else if (w_push && w_is_halt) begin
      w_state_nxt = ST_HALTED;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC update: redirect target, or advance past every non-HALT accepted word
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_push && !w_is_halt) begin
      r_pc <= w_pc_plus4;
    end
  end

  // FIFO storage write (contents need no reset; the count gates visibility)
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_instr_mem[r_tail] <= iload;
      r_npc_mem[r_tail]   <= w_pc_plus4;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST || redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect;
  logic [31:0] iload, redirect_pc;
  logic        iREN, valid_out, halted;
  logic [31:0] iaddr, instr_out, npc_out;

  logic        RST_w, ihit_w, stall_w, redirect_w;
  logic [31:0] iload_w, redirect_pc_w;
  logic        iREN_w, valid_out_w, halted_w;
  logic [31:0] iaddr_w, instr_out_w, npc_out_w;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out), .halted(halted)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) u_wrap (
    .CLK(CLK), .RST(RST_w), .ihit(ihit_w), .iload(iload_w), .iREN(iREN_w), .iaddr(iaddr_w),
    .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .instr_out(instr_out_w), .npc_out(npc_out_w), .valid_out(valid_out_w), .halted(halted_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_instr_q[$];
  logic [31:0] m_npc_q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_init = 0;

  function automatic bit m_iren();
    return !m_halted && (m_instr_q.size() < DEPTH) && !RST && !redirect;
  endfunction

  always @(posedge CLK) begin
    bit req;
    req = m_iren();
    if (RST) begin
      m_init = 1;
      m_pc = 32'h0;
      m_halted = 0;
      m_instr_q.delete();
      m_npc_q.delete();
    end else if (m_init) begin
      if (redirect) begin
        m_instr_q.delete();
        m_npc_q.delete();
        m_pc = redirect_pc & ~32'd3;
        m_halted = 0;
      end else begin
        if (m_instr_q.size() > 0 && !stall) begin
          void'(m_instr_q.pop_front());
          void'(m_npc_q.pop_front());
        end
        if (req && ihit) begin
          m_instr_q.push_back(iload);
          m_npc_q.push_back(m_pc + 32'd4);
          if (iload[31:26] == 6'b111111) m_halted = 1;
          else m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Compare process: inputs change on negedge, outputs checked once settled
  always @(negedge CLK) begin
    #2;
    if (m_init) begin
      bit v;
      v = (m_instr_q.size() != 0);
      chk("m_iREN",  {31'b0, iREN},      {31'b0, m_iren()});
      chk("m_iaddr", iaddr,              m_pc);
      chk("m_valid", {31'b0, valid_out}, {31'b0, v});
      chk("m_instr", instr_out,          v ? m_instr_q[0] : 32'h0);
      chk("m_npc",   npc_out,            v ? m_npc_q[0]   : 32'h0);
      chk("m_halt",  {31'b0, halted},    {31'b0, m_halted});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic hit, input logic [31:0] ld,
                       input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge CLK);
    RST = rst; ihit = hit; iload = ld; stall = st; redirect = rd; redirect_pc = rpc;
    #3;
  endtask

  initial begin
    RST_w = 1; ihit_w = 0; iload_w = 0; stall_w = 0; redirect_w = 0; redirect_pc_w = 0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_iren",  {31'b0, iREN}, 32'd0);
    chk("rst_halt",  {31'b0, halted}, 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_npc",   npc_out, 32'h0);
    chk("wrap_rst_iaddr", iaddr_w, 32'hFFFF_FFFC);

    // Streaming fetch, one word per cycle; wrap instance takes a single hit
    @(negedge CLK);
    RST_w = 0; ihit_w = 1; iload_w = 32'h0BAD_F00D;
    RST = 0; ihit = 1; iload = 32'h2402_0001; stall = 0;
    #3;
    chk("s0_iaddr", iaddr, 32'h0);
    chk("s0_iren",  {31'b0, iREN}, 32'd1);
    chk("s0_valid", {31'b0, valid_out}, 32'd0);
    @(negedge CLK);
    ihit_w = 0;
    iload = 32'h2403_0002;
    #3;
    chk("s1_iaddr", iaddr, 32'h4);
    chk("s1_valid", {31'b0, valid_out}, 32'd1);
    chk("s1_instr", instr_out, 32'h2402_0001);
    chk("s1_npc",   npc_out, 32'h4);
    chk("wrap_npc",   npc_out_w, 32'h0);
    chk("wrap_iaddr", iaddr_w, 32'h0);
    chk("wrap_instr", instr_out_w, 32'h0BAD_F00D);
    drive(0, 1, 32'h2404_0003, 0, 0, 0);
    chk("s2_iaddr", iaddr, 32'h8);
    chk("s2_instr", instr_out, 32'h2403_0002);
    chk("s2_npc",   npc_out, 32'h8);

    // Stall with fetch pressure, then release
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h2410_0000 + i, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h2420_0000 + i, 0, 0, 0);

    // Redirect with full FIFO and same-cycle hit; misaligned target
    drive(0, 1, 32'h2430_0000, 1, 0, 0);
    drive(0, 1, 32'h2430_0001, 1, 0, 0);
    drive(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0013);
    chk("rd_iren", {31'b0, iREN}, 32'd0);
    drive(0, 1, 32'hFFFF_FFFF, 1, 0, 0);
    chk("rd_iaddr", iaddr, 32'h10);
    chk("rd_valid", {31'b0, valid_out}, 32'd0);
    chk("rd_iren2", {31'b0, iREN}, 32'd1);
    drive(0, 1, 32'h1111_1111, 1, 0, 0);
    chk("h_halted", {31'b0, halted}, 32'd1);
    chk("h_iren",   {31'b0, iREN}, 32'd0);
    chk("h_instr",  instr_out, 32'hFFFF_FFFF);
    chk("h_npc",    npc_out, 32'h14);
    chk("h_iaddr",  iaddr, 32'h10);
    drive(0, 1, 32'h1111_1111, 0, 0, 0);
    chk("h_valid",  {31'b0, valid_out}, 32'd1);
    drive(0, 1, 32'h1111_1111, 0, 0, 0);
    chk("h_drained", {31'b0, valid_out}, 32'd0);
    chk("h_still",   {31'b0, halted}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'h0000_0040);
    chk("h_rd_iren", {31'b0, iREN}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("h_resume_halt",  {31'b0, halted}, 32'd0);
    chk("h_resume_iaddr", iaddr, 32'h40);
    chk("h_resume_iren",  {31'b0, iREN}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ld;
      ld = $urandom;
      if ($urandom_range(0, 19) == 0) ld[31:26] = 6'b111111;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, ld,
            $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0, $urandom);
    end

    @(negedge CLK);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/control unit.
- Owns the PC and drives the instruction-memory request handshake (iREN/iaddr/ihit/iload).
- Buffers fetched words in a small FIFO so decode stalls do not drop instructions.
- Presents {instruction, PC+4, valid} to decode; honours redirects from branch/jump resolution and stops fetching after a HALT word.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, fetch FIFO entries (power of two, >=2)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
ihit  in  1  imem response valid this cycle for the current iaddr
iload  in  32  imem read data, meaningful only when ihit=1
iREN  out  1  imem read request
iaddr  out  32  imem address (= pc)
stall  in  1  decode cannot accept the head entry this cycle
redirect  in  1  branch/jump resolved taken, from downstream
redirect_pc  in  32  target PC; bits [1:0] ignored, treated as 00
instr_out  out  32  head-of-FIFO instruction to decode
npc_out  out  32  PC+4 of the head instruction
valid_out  out  1  head entry valid
halted  out  1  fetch has stopped on a HALT word

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: pc=RESET_PC; FIFO count=0; state=FETCH; iREN=0 during the RST cycle; valid_out=0; instr_out=0; npc_out=0; halted=0.
- States: FETCH and HALTED.
- iREN = (state==FETCH) & (count<BUF_DEPTH) & !RST & !redirect.
- iaddr = pc at all times.
- Fetch accept (iREN & ihit & !redirect):
  - push {iload, pc+4} to the FIFO tail;
  - pc <= pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
- HALT detection: if the accepted iload[31:26]==6'b111111:
  - the HALT word is pushed normally;
  - state -> HALTED and pc holds.
- In HALTED:
  - iREN=0 and halted=1;
  - the FIFO keeps draining to decode.
- Output side:
  - valid_out = (count!=0);
  - instr_out and npc_out come from the FIFO head combinationally;
  - when count==0, instr_out=0 (NOP) and npc_out=0.
- Pop when valid_out & !stall. Push and pop in the same cycle leave count unchanged.
- Full FIFO: iREN is deasserted (no speculative push-while-pop); the request reasserts the cycle after count drops.
- Redirect (highest priority, any state):
  - flush the FIFO (count<=0, no pop credited);
  - discard any same-cycle ihit/iload;
  - pc <= {redirect_pc[31:2], 2'b00};
  - state -> FETCH, halted <= 0;
  - iREN is low in the redirect cycle and requests the new pc next cycle.
- ihit while iREN=0 is ignored.
- iREN holds with a stable iaddr until ihit; imem latency is unbounded.
- RST mid-request: the request is abandoned and any ihit in the RST cycle is ignored.
- Latency:
  - a word accepted on edge N appears at instr_out with valid_out=1 after edge N;
  - minimum fetch-to-decode latency is 1 cycle;
  - sustained throughput is 1 instruction/cycle when ihit=1 every cycle and stall=0.

Test Plan:
- Reset then ihit=1 every cycle, stall=0, iload=32'h2402_0001,32'h2403_0002,... -> iaddr 0,4,8; valid_out=1 from cycle 1; npc_out 4,8,12; one instruction per cycle.
- Hold stall=1 for 4 cycles with ihit=1 -> two pushes; iREN drops at count=2; iaddr frozen at 8; instr_out holds the first word; release -> words at 0 and 4 drain in order, fetch resumes at 8.
- Redirect=1, redirect_pc=32'h0000_0103 with ihit=1 in the same cycle and count=2 -> FIFO empties; iload discarded; next iaddr=32'h0000_0100; valid_out=0 for one cycle.
- iload=32'hFFFF_FFFF accepted at pc=0x10 -> pushed; halted=1 next cycle; iREN stays 0; pc=0x10; the HALT word is still delivered to decode; then redirect_pc=0x40 -> halted=0, fetch at 0x40.
- RESET_PC=32'hFFFF_FFFC with one ihit -> npc_out=0 and next iaddr=0 (wrap).
- RST asserted mid-sequence with count=1 and ihit=1 -> next cycle valid_out=0, iaddr=RESET_PC, halted=0.
